pe_ctrl_seq: RTL and testbench

PE_CTRL_SEQ -- requirements
Module: pe_ctrl_seq

---
 rtl/pe_pkg.sv | 85 ++++++++
 rtl/wb_delay_line.sv | 23 ++
 rtl/pe_ctrl_seq.sv | 133 +++++++++++++
 tb/tb_pe_ctrl_seq.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the PE control sequencer: opcodes, DSP mode encodings,
// instruction field positions and the per-lane decode helper.
package pe_pkg;

   localparam int ALUMODE_W = 4;
   localparam int INMODE_W  = 5;
   localparam int OPMODE_W  = 7;

   localparam int OPC_LSB  = 29;
   localparam int OPC_W    = 3;
   localparam int RPT_LSB  = 21;
   localparam int MASK_LSB = 32;

   typedef enum logic [2:0] {
      OP_NOP    = 3'b000,
      OP_ADD    = 3'b001,
      OP_SUB    = 3'b010,
      OP_RSV    = 3'b011,
      OP_MUL    = 3'b100,
      OP_MULADD = 3'b101,
      OP_MULSUB = 3'b110,
      OP_MAX    = 3'b111
   } opcode_e;

   localparam logic [ALUMODE_W-1:0] ALU_ADD = 4'b0000;
   localparam logic [ALUMODE_W-1:0] ALU_SUB = 4'b0011;
   localparam logic [ALUMODE_W-1:0] ALU_MAX = 4'b1100;

   localparam logic [INMODE_W-1:0] INM_AB  = 5'b00000;
   localparam logic [INMODE_W-1:0] INM_MUL = 5'b10001;

   localparam logic [OPMODE_W-1:0] OPM_ADD = 7'b0110011;
   localparam logic [OPMODE_W-1:0] OPM_MUL = 7'b0000101;
   localparam logic [OPMODE_W-1:0] OPM_MAC = 7'b0110101;

   typedef struct packed {
      logic [ALUMODE_W-1:0] alumode;
      logic [INMODE_W-1:0]  inmode;
      logic [OPMODE_W-1:0]  opmode;
      logic                 cea2;
      logic                 ceb2;
      logic                 usemult;
   } lane_ctrl_t;

   localparam lane_ctrl_t LANE_LOAD = '0;

   function automatic logic isNop(input opcode_e opc);
      return (opc == OP_NOP) || (opc == OP_RSV);
   endfunction

   // Odd lanes accumulate the neighbouring product in the fused MAC opcodes.
   function automatic lane_ctrl_t decodeLane(input opcode_e opc, input logic oddLane);
      lane_ctrl_t c;
      c = LANE_LOAD;
      case (opc)
         OP_ADD, OP_SUB: begin
            c.alumode = (opc == OP_SUB) ? ALU_SUB : ALU_ADD;
            c.inmode  = INM_AB;
            c.opmode  = OPM_ADD;
            c.cea2    = 1'b1;
            c.ceb2    = 1'b1;
         end
         OP_MUL: begin
            c.inmode  = INM_MUL;
            c.opmode  = OPM_MUL;
            c.usemult = 1'b1;
         end
         OP_MULADD, OP_MULSUB: begin
            c.alumode = (opc == OP_MULSUB && oddLane) ? ALU_SUB : ALU_ADD;
            c.inmode  = INM_MUL;
            c.opmode  = oddLane ? OPM_MAC : OPM_MUL;
            c.usemult = 1'b1;
         end
         OP_MAX: begin
            c.alumode = ALU_MAX;
            c.inmode  = INM_AB;
            c.opmode  = OPM_ADD;
            c.usemult = 1'b1;
         end
         default: c = LANE_LOAD;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/wb_delay_line.sv
// Fixed-latency 1-bit shift register that times the writeback valid strobe.
module wb_delay_line #(
   parameter int DEPTH = 6
) (
   input  logic clk,
   input  logic rst,
   input  logic pulse_i,
   output logic pulse_o
);

   logic [DEPTH-1:0] shift_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
      end else begin
         shift_q <= {shift_q[DEPTH-2:0], pulse_i};
      end
   end

   assign pulse_o = shift_q[DEPTH-1];

endmodule

// File: rtl/pe_ctrl_seq.sv
// Instruction sequencer that drives per-lane DSP control words for R+1 cycles
// per instruction and times the result writeback onto dout.
module pe_ctrl_seq
   import pe_pkg::*;
#(
   parameter int NUM_LANES  = 4,
   parameter int DATA_WIDTH = 16,
   parameter int INST_WIDTH = 64,
   parameter int WB_DELAY   = 6,
   parameter int RPT_WIDTH  = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            inst_v,
   output logic                            inst_rdy,
   input  logic [INST_WIDTH-1:0]           inst,
   input  logic                            din_ld_v,
   input  logic [2*DATA_WIDTH-1:0]         din_ld,
   input  logic [2*DATA_WIDTH-1:0]         din_wb,
   output logic                            dout_v,
   output logic [2*DATA_WIDTH-1:0]         dout,
   output logic [ALUMODE_W*NUM_LANES-1:0]  alumode,
   output logic [INMODE_W*NUM_LANES-1:0]   inmode,
   output logic [OPMODE_W*NUM_LANES-1:0]   opmode,
   output logic [NUM_LANES-1:0]            cea2,
   output logic [NUM_LANES-1:0]            ceb2,
   output logic [NUM_LANES-1:0]            usemult,
   output logic                            busy,
   output logic                            ld_drop
);

   typedef enum logic {IDLE, EXEC} state_e;

   state_e                   state_q, state_d;
   logic [RPT_WIDTH-1:0]     repCnt_q, repCnt_d;
   opcode_e                  opcode_q, opcode_d;
   logic [NUM_LANES-1:0]     laneMask_q, laneMask_d;
   logic [2*DATA_WIDTH-1:0]  dout_q;
   logic                     ldDrop_q;
   logic                     accept;
   logic                     wordActive;
   lane_ctrl_t               laneCtrl;
   logic                     unusedInst;

   assign unusedInst = ^{inst[INST_WIDTH-1:MASK_LSB+NUM_LANES], inst[RPT_LSB-1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         repCnt_q   <= '0;
         opcode_q   <= OP_NOP;
         laneMask_q <= '0;
      end else begin
         state_q    <= state_d;
         repCnt_q   <= repCnt_d;
         opcode_q   <= opcode_d;
         laneMask_q <= laneMask_d;
      end
   end

   // Readiness in the final repetition lets the next instruction follow with no bubble.
   always_comb begin
      state_d    = state_q;
      repCnt_d   = repCnt_q;
      opcode_d   = opcode_q;
      laneMask_d = laneMask_q;
      inst_rdy   = (state_q == IDLE) || (repCnt_q == '0);
      accept     = inst_v && inst_rdy;
      if (accept) begin
         state_d    = EXEC;
         repCnt_d   = inst[RPT_LSB +: RPT_WIDTH];
         opcode_d   = opcode_e'(inst[OPC_LSB +: OPC_W]);
         laneMask_d = inst[MASK_LSB +: NUM_LANES];
      end else if (state_q == EXEC) begin
         if (repCnt_q == '0) begin
            state_d = IDLE;
         end else begin
            repCnt_d = repCnt_q - 1'b1;
         end
      end
   end

   always_comb begin
      alumode  = '0;
      inmode   = '0;
      opmode   = '0;
      cea2     = '0;
      ceb2     = '0;
      usemult  = '0;
      laneCtrl = LANE_LOAD;
      for (int i = 0; i < NUM_LANES; i++) begin
         laneCtrl = LANE_LOAD;
         if (state_q == EXEC && laneMask_q[i]) begin
            laneCtrl = decodeLane(opcode_q, (i % 2) == 1);
         end
         alumode[i*ALUMODE_W +: ALUMODE_W] = laneCtrl.alumode;
         inmode[i*INMODE_W +: INMODE_W]    = laneCtrl.inmode;
         opmode[i*OPMODE_W +: OPMODE_W]    = laneCtrl.opmode;
         cea2[i]                           = laneCtrl.cea2;
         ceb2[i]                           = laneCtrl.ceb2;
         usemult[i]                        = laneCtrl.usemult;
      end
   end

   assign busy       = (state_q == EXEC);
   assign wordActive = busy && !isNop(opcode_q) && (|laneMask_q);

   wb_delay_line #(.DEPTH(WB_DELAY)) uDelay (
      .clk     (clk),
      .rst     (rst),
      .pulse_i (wordActive),
      .pulse_o (dout_v)
   );

   // Writeback wins over a concurrent load; the load is discarded and flagged.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q   <= '0;
         ldDrop_q <= 1'b0;
      end else begin
         if (dout_v) begin
            dout_q <= din_wb;
         end else if (din_ld_v) begin
            dout_q <= din_ld;
         end
         ldDrop_q <= dout_v && din_ld_v;
      end
   end

   assign dout    = dout_q;
   assign ld_drop = ldDrop_q;

endmodule

// File: tb/tb_pe_ctrl_seq.sv
// Directed self-checking bench for pe_ctrl_seq with hand-computed expectations.
module tb_pe_ctrl_seq;

   localparam int NL  = 4;
   localparam int DW  = 16;
   localparam int IW  = 64;
   localparam int WBD = 6;
   localparam int RW  = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            inst_v;
   logic            inst_rdy;
   logic [IW-1:0]   inst;
   logic            din_ld_v;
   logic [2*DW-1:0] din_ld;
   logic [2*DW-1:0] din_wb;
   logic            dout_v;
   logic [2*DW-1:0] dout;
   logic [4*NL-1:0] alumode;
   logic [5*NL-1:0] inmode;
   logic [7*NL-1:0] opmode;
   logic [NL-1:0]   cea2;
   logic [NL-1:0]   ceb2;
   logic [NL-1:0]   usemult;
   logic            busy;
   logic            ld_drop;

   int errors = 0;
   int checks = 0;

   pe_ctrl_seq #(
      .NUM_LANES(NL), .DATA_WIDTH(DW), .INST_WIDTH(IW), .WB_DELAY(WBD), .RPT_WIDTH(RW)
   ) dut (
      .clk(clk), .rst(rst), .inst_v(inst_v), .inst_rdy(inst_rdy), .inst(inst),
      .din_ld_v(din_ld_v), .din_ld(din_ld), .din_wb(din_wb),
      .dout_v(dout_v), .dout(dout),
      .alumode(alumode), .inmode(inmode), .opmode(opmode),
      .cea2(cea2), .ceb2(ceb2), .usemult(usemult),
      .busy(busy), .ld_drop(ld_drop)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [IW-1:0] mkInst(input logic [2:0] opc, input logic [7:0] rpt,
                                            input logic [3:0] mask);
      logic [IW-1:0] v;
      v        = '0;
      v[31:29] = opc;
      v[28:21] = rpt;
      v[35:32] = mask;
      return v;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy);
      end
      checks++;
      if ({alumode, inmode, opmode, cea2, ceb2, usemult} !== '0) begin
         errors++; $display("[TB] FAIL reset_ctrl got opm=%h alu=%h inm=%h exp=0", opmode, alumode, inmode);
      end
      checks++;
      if ({dout_v, ld_drop, dout} !== '0) begin
         errors++; $display("[TB] FAIL reset_dout got v=%b drop=%b dout=%h exp=0", dout_v, ld_drop, dout);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (inst_rdy !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_rdy got=%b exp=1", inst_rdy);
      end
   endtask

   task automatic test_mul();
      din_wb = 32'hCAFEF00D;
      inst   = mkInst(3'b100, 8'd0, 4'hF);
      inst_v = 1'b1;
      tick();
      inst_v = 1'b0;
      checks++;
      if (opmode !== {4{7'b0000101}} || inmode !== {4{5'b10001}} || usemult !== 4'hF) begin
         errors++; $display("[TB] FAIL mul_ctrl got opm=%h inm=%h um=%h exp opm=%h inm=%h um=f",
                            opmode, inmode, usemult, {4{7'b0000101}}, {4{5'b10001}});
      end
      checks++;
      if ({alumode, cea2, ceb2} !== '0 || busy !== 1'b1) begin
         errors++; $display("[TB] FAIL mul_misc got alu=%h ce=%b%b busy=%b exp 0/1", alumode, cea2, ceb2, busy);
      end
      for (int k = 2; k <= 9; k++) begin
         tick();
         if (k == 2) begin
            checks++;
            if (opmode !== '0 || busy !== 1'b0) begin
               errors++; $display("[TB] FAIL mul_after got opm=%h busy=%b exp 0", opmode, busy);
            end
         end
         checks++;
         if (dout_v !== (k == 7)) begin
            errors++; $display("[TB] FAIL mul_doutv c%0d got=%b exp=%b", k, dout_v, (k == 7));
         end
      end
      checks++;
      if (dout !== 32'hCAFEF00D) begin
         errors++; $display("[TB] FAIL mul_dout got=%h exp=cafef00d", dout);
      end
   endtask

   task automatic test_muladd();
      logic act;
      inst   = mkInst(3'b101, 8'd3, 4'b0101);
      inst_v = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         inst_v = 1'b0;
         act    = (k <= 4);
         checks++;
         if (opmode !== (act ? {7'b0, 7'b0000101, 7'b0, 7'b0000101} : 28'h0) ||
             inmode !== (act ? {5'b0, 5'b10001, 5'b0, 5'b10001} : 20'h0) ||
             usemult !== (act ? 4'b0101 : 4'b0000)) begin
            errors++; $display("[TB] FAIL muladd_ctrl c%0d got opm=%h inm=%h um=%b", k, opmode, inmode, usemult);
         end
         checks++;
         if (busy !== act || inst_rdy !== (k >= 4)) begin
            errors++; $display("[TB] FAIL muladd_hs c%0d got busy=%b rdy=%b exp busy=%b rdy=%b",
                               k, busy, inst_rdy, act, (k >= 4));
         end
         checks++;
         if (dout_v !== (k >= 7 && k <= 10)) begin
            errors++; $display("[TB] FAIL muladd_doutv c%0d got=%b exp=%b", k, dout_v, (k >= 7 && k <= 10));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [27:0] expOpm;
      logic [15:0] expAlu;
      inst   = mkInst(3'b001, 8'd1, 4'hF);
      inst_v = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         tick();
         if (k == 1) inst = mkInst(3'b010, 8'd0, 4'hF);
         if (k == 3) inst_v = 1'b0;
         expOpm = (k <= 3) ? {4{7'b0110011}} : 28'h0;
         expAlu = (k == 3) ? 16'h3333 : 16'h0000;
         checks++;
         if (opmode !== expOpm || alumode !== expAlu || cea2 !== ((k <= 3) ? 4'hF : 4'h0)) begin
            errors++; $display("[TB] FAIL b2b_ctrl c%0d got opm=%h alu=%h ce=%b exp opm=%h alu=%h",
                               k, opmode, alumode, cea2, expOpm, expAlu);
         end
         checks++;
         if (busy !== (k <= 3) || inst_rdy !== (k != 1)) begin
            errors++; $display("[TB] FAIL b2b_hs c%0d got busy=%b rdy=%b exp busy=%b rdy=%b",
                               k, busy, inst_rdy, (k <= 3), (k != 1));
         end
         checks++;
         if (dout_v !== (k >= 7 && k <= 9)) begin
            errors++; $display("[TB] FAIL b2b_doutv c%0d got=%b exp=%b", k, dout_v, (k >= 7 && k <= 9));
         end
      end
   endtask

   task automatic test_decode();
      logic [15:0] expAlu;
      logic [19:0] expInm;
      logic [27:0] expOpm;
      logic [3:0]  expUm;
      for (int t = 0; t < 2; t++) begin
         if (t == 0) begin
            inst   = mkInst(3'b111, 8'd0, 4'b0011);
            expAlu = 16'h00CC;
            expInm = 20'h0;
            expOpm = {7'b0, 7'b0, 7'b0110011, 7'b0110011};
            expUm  = 4'b0011;
         end else begin
            inst   = mkInst(3'b110, 8'd0, 4'hF);
            expAlu = 16'h3030;
            expInm = {4{5'b10001}};
            expOpm = {7'b0110101, 7'b0000101, 7'b0110101, 7'b0000101};
            expUm  = 4'hF;
         end
         inst_v = 1'b1;
         tick();
         inst_v = 1'b0;
         checks++;
         if (alumode !== expAlu || inmode !== expInm || opmode !== expOpm ||
             usemult !== expUm || cea2 !== 4'h0) begin
            errors++; $display("[TB] FAIL decode%0d got alu=%h inm=%h opm=%h um=%b exp alu=%h inm=%h opm=%h um=%b",
                               t, alumode, inmode, opmode, usemult, expAlu, expInm, expOpm, expUm);
         end
         for (int k = 2; k <= 8; k++) begin
            tick();
            checks++;
            if (dout_v !== (k == 7)) begin
               errors++; $display("[TB] FAIL decode%0d_doutv c%0d got=%b exp=%b", t, k, dout_v, (k == 7));
            end
         end
      end
   endtask

   task automatic test_collision();
      inst   = mkInst(3'b001, 8'd0, 4'b0001);
      inst_v = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         inst_v = 1'b0;
         checks++;
         if (dout_v !== (k == 7)) begin
            errors++; $display("[TB] FAIL coll_doutv c%0d got=%b exp=%b", k, dout_v, (k == 7));
         end
      end
      din_wb   = 32'h12345678;
      din_ld   = 32'hAAAA5555;
      din_ld_v = 1'b1;
      tick();
      din_ld_v = 1'b0;
      checks++;
      if (dout !== 32'h12345678 || ld_drop !== 1'b1) begin
         errors++; $display("[TB] FAIL coll_prio got dout=%h drop=%b exp 12345678/1", dout, ld_drop);
      end
      tick();
      checks++;
      if (dout !== 32'h12345678 || ld_drop !== 1'b0) begin
         errors++; $display("[TB] FAIL coll_hold got dout=%h drop=%b exp 12345678/0", dout, ld_drop);
      end
      din_ld   = 32'h0BADBEEF;
      din_ld_v = 1'b1;
      tick();
      din_ld_v = 1'b0;
      checks++;
      if (dout !== 32'h0BADBEEF || ld_drop !== 1'b0) begin
         errors++; $display("[TB] FAIL plain_load got dout=%h drop=%b exp 0badbeef/0", dout, ld_drop);
      end
   endtask

   task automatic test_mid_reset();
      inst   = mkInst(3'b100, 8'd5, 4'hF);
      inst_v = 1'b1;
      tick();
      inst_v = 1'b0;
      tick();
      tick();
      checks++;
      if (opmode !== {4{7'b0000101}} || busy !== 1'b1) begin
         errors++; $display("[TB] FAIL midrst_pre got opm=%h busy=%b", opmode, busy);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (opmode !== '0 || usemult !== '0 || busy !== 1'b0 || dout !== '0) begin
         errors++; $display("[TB] FAIL midrst_ctrl got opm=%h um=%b busy=%b dout=%h exp 0",
                            opmode, usemult, busy, dout);
      end
      for (int k = 4; k <= 10; k++) begin
         checks++;
         if (dout_v !== 1'b0 || inst_rdy !== 1'b1) begin
            errors++; $display("[TB] FAIL midrst_post c%0d got doutv=%b rdy=%b exp 0/1", k, dout_v, inst_rdy);
         end
         tick();
      end
   endtask

   task automatic test_nop();
      inst   = mkInst(3'b000, 8'd2, 4'hF);
      inst_v = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         tick();
         inst_v = 1'b0;
         checks++;
         if (busy !== (k <= 3) || {alumode, inmode, opmode, cea2, ceb2, usemult} !== '0 || dout_v !== 1'b0) begin
            errors++; $display("[TB] FAIL nop c%0d got busy=%b opm=%h doutv=%b exp busy=%b", k, busy, opmode,
                               dout_v, (k <= 3));
         end
      end
   endtask

   task automatic test_zero_mask();
      inst   = mkInst(3'b100, 8'd0, 4'h0);
      inst_v = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         inst_v = 1'b0;
         checks++;
         if (busy !== (k == 1) || opmode !== '0 || dout_v !== 1'b0) begin
            errors++; $display("[TB] FAIL zeromask c%0d got busy=%b opm=%h doutv=%b", k, busy, opmode, dout_v);
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      inst_v   = 1'b0;
      inst     = '0;
      din_ld_v = 1'b0;
      din_ld   = '0;
      din_wb   = '0;
      test_reset();
      test_mul();
      test_muladd();
      test_back_to_back();
      test_decode();
      test_collision();
      test_mid_reset();
      test_nop();
      test_zero_mask();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
